// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL reset, qualifies lock, releases domain resets in a staggered order.
// Latency: pll_locked reaches the FSM after 2 cycles; every output is a flop updated from the next-state decision.
// No backpressure; lock loss or sw_restart forces a full PLL restart, all domains drop together.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 32,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int NUM_DOMAINS        = 3,
  parameter int STAGGER_CYCLES     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   pll_rst,
  input  logic                   pll_locked,
  input  logic                   sw_restart,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic [2:0]             state_dbg
);

  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RELEASE   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  // Shared counter must hold the longest dwell of any state.
  localparam int STAGGER_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (RELOCK_TIMEOUT > STAGGER_SPAN) ? RELOCK_TIMEOUT : STAGGER_SPAN;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT + 1);

  // Terminal counts: the transition fires on the last cycle of each dwell.
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_DOMAINS > 1) ? (STAGGER_SPAN - 1) : 0);

  logic                   sync_q1;
  logic                   locked_s;
  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [31:0]            cnt_nxt_w;
  logic                   bump;
  logic [7:0]             relock_nxt;
  logic [NUM_DOMAINS-1:0] domain_nxt;
  logic                   ready_nxt;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked;
      locked_s <= sync_q1;
    end
  end

  // Next-state decision; sw_restart outranks lock loss so it never counts as a recovery.
  always_comb begin
    state_nxt = state;
    bump      = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (sw_restart) begin
          state_nxt = RESET_PLL;
        end else if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = RESET_PLL;
          bump      = 1'b1;
        end
      end
      STABLE: begin
        if (sw_restart) begin
          state_nxt = RESET_PLL;
        end else if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (sw_restart) begin
          state_nxt = RESET_PLL;
        end else if (!locked_s) begin
          state_nxt = RESET_PLL;
          bump      = 1'b1;
        end else if (NUM_DOMAINS == 1 || cnt == RELEASE_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (sw_restart) begin
          state_nxt = RESET_PLL;
        end else if (!locked_s) begin
          state_nxt = RESET_PLL;
          bump      = 1'b1;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

  // Counter restarts on every state change; RUN has no dwell so it parks at zero.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (state_nxt != state || state == RUN) cnt_nxt = '0;
    cnt_nxt_w = 32'(cnt_nxt);
  end

  // Output values for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    domain_nxt = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      domain_nxt[i] = (state_nxt == RUN) ||
                      (state_nxt == RELEASE && cnt_nxt_w >= 32'(i * STAGGER_CYCLES));
    end
    ready_nxt  = (state_nxt == RUN) || (state_nxt == RELEASE && NUM_DOMAINS == 1);
    relock_nxt = (bump && relock_count != 8'hFF) ? relock_count + 8'd1 : relock_count;
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RESET_PLL;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pll_rst      <= (state_nxt == RESET_PLL);
      domain_rst_n <= domain_nxt;
      ready        <= ready_nxt;
      relock_count <= relock_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios plus randomized lock/restart traffic against a phase/elapsed-time model.
// Latency: model tracks the 2-cycle lock synchronizer and registered outputs.
// No backpressure; inputs change on falling edges, outputs compared on falling edges.
module tb_pll_reset_sequencer;
  localparam int P_RST  = 4;
  localparam int P_STAB = 8;
  localparam int P_TO   = 64;
  localparam int ND     = 3;
  localparam int SG     = 2;

  logic          clk;
  logic          rst_n;
  logic          pll_rst;
  logic          pll_locked;
  logic          sw_restart;
  logic [ND-1:0] domain_rst_n;
  logic          ready;
  logic [7:0]    relock_count;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST), .LOCK_STABLE_CYCLES(P_STAB), .RELOCK_TIMEOUT(P_TO),
    .NUM_DOMAINS(ND), .STAGGER_CYCLES(SG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_rst(pll_rst), .pll_locked(pll_locked),
    .sw_restart(sw_restart), .domain_rst_n(domain_rst_n), .ready(ready),
    .relock_count(relock_count), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: phase (0 reset PLL, 1 wait lock, 2 stable, 3 release, 4 run)
  // and time spent in it; outputs follow directly from phase and elapsed time.
  int m_phase = 0;
  int m_t     = 0;
  int m_rc    = 0;
  bit m_q1    = 0;
  bit m_q2    = 0;

  always @(posedge clk) begin
    bit ls;
    bit bump;
    int np;
    if (!rst_n) begin
      m_phase = 0; m_t = 0; m_rc = 0; m_q1 = 0; m_q2 = 0;
    end else begin
      ls   = m_q2;
      np   = m_phase;
      bump = 0;
      if (m_phase == 0) begin
        if (m_t + 1 >= P_RST) np = 1;
      end else if (sw_restart) begin
        np = 0;
      end else if (m_phase == 1) begin
        if (ls) np = 2;
        else if (m_t + 1 >= P_TO) begin np = 0; bump = 1; end
      end else if (m_phase == 2) begin
        if (!ls) np = 1;
        else if (m_t + 1 >= P_STAB) np = 3;
      end else begin
        if (!ls) begin np = 0; bump = 1; end
        else if (m_phase == 3 && m_t + 1 >= (ND - 1) * SG) np = 4;
      end
      if (bump && m_rc < 255) m_rc++;
      m_t     = (np == m_phase) ? m_t + 1 : 0;
      m_phase = np;
      m_q2    = m_q1;
      m_q1    = pll_locked;
    end
  end

  function automatic int exp_domains();
    int v = 0;
    for (int i = 0; i < ND; i++)
      if (m_phase == 4 || (m_phase == 3 && m_t >= i * SG)) v |= (1 << i);
    return v;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pll_rst", int'(pll_rst), int'(m_phase == 0));
      check("domain_rst_n", int'(domain_rst_n), exp_domains());
      check("ready", int'(ready), int'(m_phase == 4));
      check("relock_count", int'(relock_count), m_rc);
      check("state_dbg", int'(state_dbg), m_phase);
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0;
    int last_rise;
    int rises;
    bit prev;
    rst_n = 1'b0; pll_locked = 1'b0; sw_restart = 1'b0;

    // Power-up: three reset cycles, then the 4-cycle PLL reset pulse.
    nxt(1);
    cmp_en = 1;
    nxt(2);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_domains", int'(domain_rst_n), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_state", int'(state_dbg), 0);
    rst_n = 1'b1;
    nxt(3);
    check("pwr_pll_rst_last", int'(pll_rst), 1);
    nxt(1);
    check("pwr_pll_rst_low", int'(pll_rst), 0);
    check("pwr_state", int'(state_dbg), 1);

    // Clean lock at T.
    nxt(5);
    pll_locked = 1'b1;
    nxt(10);
    check("clean_T10", int'(domain_rst_n), 0);
    nxt(1);
    check("clean_T11", int'(domain_rst_n), 1);
    nxt(2);
    check("clean_T13", int'(domain_rst_n), 3);
    nxt(2);
    check("clean_T15", int'(domain_rst_n), 7);
    check("clean_ready", int'(ready), 1);
    check("clean_rc", int'(relock_count), 0);

    // One-cycle lock loss in RUN.
    nxt(3);
    pll_locked = 1'b0;
    nxt(1);
    pll_locked = 1'b1;
    nxt(1);
    check("loss_D2_dom", int'(domain_rst_n), 7);
    nxt(1);
    check("loss_dom", int'(domain_rst_n), 0);
    check("loss_ready", int'(ready), 0);
    check("loss_pll_rst", int'(pll_rst), 1);
    check("loss_rc", int'(relock_count), 1);
    nxt(3);
    check("loss_pll_rst_last", int'(pll_rst), 1);
    nxt(1);
    check("loss_pll_rst_low", int'(pll_rst), 0);
    nxt(20);
    check("loss_relocked", int'(ready), 1);

    // Glitchy lock: 5 high, 1 low, then high from F.
    pll_locked = 1'b0;
    nxt(20);
    pll_locked = 1'b1;
    nxt(5);
    pll_locked = 1'b0;
    nxt(1);
    pll_locked = 1'b1;
    nxt(10);
    check("glitch_F10", int'(domain_rst_n), 0);
    nxt(1);
    check("glitch_F11", int'(domain_rst_n), 1);
    check("glitch_rc", int'(relock_count), 2);

    // sw_restart in RELEASE at 3'b011 coinciding with a synchronized lock drop.
    pll_locked = 1'b0;
    nxt(2);
    check("sw_pre_dom", int'(domain_rst_n), 3);
    sw_restart = 1'b1;
    nxt(1);
    sw_restart = 1'b0;
    check("sw_dom", int'(domain_rst_n), 0);
    check("sw_state", int'(state_dbg), 0);
    check("sw_rc", int'(relock_count), 2);

    // Mid-operation reset, then lock never arrives: periodic re-pulse and saturation.
    nxt(5);
    rst_n = 1'b0;
    nxt(1);
    check("mid_rst_rc", int'(relock_count), 0);
    rst_n = 1'b1;
    prev = 1'b1;
    rises = 0;
    last_rise = 0;
    for (int k = 0; k < 258 * (P_TO + P_RST) + 10; k++) begin
      nxt(1);
      if (pll_rst && !prev) begin
        rises++;
        if (rises > 1 && rises < 6) check("repulse_period", cyc - last_rise, 68);
        check("timeout_rc", int'(relock_count), (rises > 255) ? 255 : rises);
        last_rise = cyc;
      end
      prev = pll_rst;
    end
    check("timeout_rises", rises, 258);
    check("sat_rc", int'(relock_count), 255);

    // Randomized lock flapping, restarts and resets.
    rst_n = 1'b0;
    nxt(1);
    rst_n = 1'b1;
    t0 = 0;
    for (int k = 0; k < 4000; k++) begin
      nxt(1);
      sw_restart = ($urandom_range(149) == 0);
      rst_n      = ($urandom_range(999) != 0);
      if ($urandom_range(39) == 0) begin
        pll_locked = ~pll_locked;
        t0++;
      end
    end
    sw_restart = 1'b0;
    rst_n = 1'b1;
    nxt(2);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
